// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light vehicle sensor front end.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL_ON  = 2'd1,
    PRESENT  = 2'd2,
    QUAL_OFF = 2'd3
  } sens_state_t;

  localparam logic [7:0] VEH_COUNT_MAX = 8'd255;

  // Vehicle count increments but never wraps past VEH_COUNT_MAX.
  function automatic logic [7:0] veh_count_inc(input logic [7:0] v);
    return (v == VEH_COUNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vehicle_sensor_conditioner_sync2.sv
// sync2: two-flop synchroniser for an asynchronous input, async active-low reset.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Vehicle loop conditioner: synchronise, debounce, latch service request, count arrivals.
// Optional stuck-loop detection is built when SENSOR_STUCK_DET_EN is defined.
module vehicle_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned STUCK_CYCLES    = 60000,
  parameter int unsigned STUCK_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_raw,
  input  logic       req_ack,
  output logic       veh_req,
  output logic [7:0] veh_count,
  output logic       stuck_fault
);

  localparam logic [CNT_W:0]   DEB_LIM = (CNT_W+1)'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam bit               DEB_ONE = (DEBOUNCE_CYCLES == 1);

  logic              w_sensor_s;
  sens_state_t       r_state;
  sens_state_t       w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W:0]    w_cnt_inc;
  logic              w_arrival;
  logic              w_fault_nxt;
  logic              r_req;
  logic [7:0]        r_count;

  sync2 #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (sensor_raw),
    .o_q (w_sensor_s)
  );

  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};

  // Counter only ever climbs to DEB_LIM, where the state changes and it clears.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_arrival   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sensor_s) begin
          if (DEB_ONE) begin
            w_state_nxt = PRESENT;
            w_cnt_nxt   = '0;
            w_arrival   = 1'b1;
          end else begin
            w_state_nxt = QUAL_ON;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      QUAL_ON: begin
        if (!w_sensor_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc >= DEB_LIM) begin
          w_state_nxt = PRESENT;
          w_cnt_nxt   = '0;
          w_arrival   = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
        end
      end
      PRESENT: begin
        if (!w_sensor_s) begin
          if (DEB_ONE) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = QUAL_OFF;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      QUAL_OFF: begin
        if (w_sensor_s) begin
          w_state_nxt = PRESENT;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc >= DEB_LIM) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef SENSOR_STUCK_DET_EN
  localparam logic [STUCK_W:0] STUCK_LIM = (STUCK_W+1)'(STUCK_CYCLES);

  logic [STUCK_W-1:0] r_stuck_tmr;
  logic [STUCK_W:0]   w_tmr_inc;
  logic               w_stay_present;
  logic               r_fault;

  assign w_stay_present = (r_state == PRESENT) && (w_state_nxt == PRESENT);
  assign w_tmr_inc      = {1'b0, r_stuck_tmr} + {{STUCK_W{1'b0}}, 1'b1};
  assign w_fault_nxt    = r_fault | (w_stay_present && (w_tmr_inc >= STUCK_LIM));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stuck_tmr <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_fault <= w_fault_nxt;
      if (w_stay_present) begin
        if (w_tmr_inc <= STUCK_LIM) begin
          r_stuck_tmr <= w_tmr_inc[STUCK_W-1:0];
        end
      end else begin
        r_stuck_tmr <= '0;
      end
    end
  end

  assign stuck_fault = r_fault;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{32'(STUCK_CYCLES), 32'(STUCK_W)};
  assign w_fault_nxt  = 1'b0;
  assign stuck_fault  = 1'b0;
`endif

  // Arrival (and a stuck loop, when built) takes priority over acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req   <= 1'b0;
      r_count <= 8'd0;
    end else begin
      if (w_arrival || w_fault_nxt) begin
        r_req <= 1'b1;
      end else if (req_ack) begin
        r_req <= 1'b0;
      end
      if (w_arrival) begin
        r_count <= veh_count_inc(r_count);
      end
    end
  end

  assign veh_req   = r_req;
  assign veh_count = r_count;

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Directed bench for vehicle_sensor_conditioner (DEBOUNCE_CYCLES=4, STUCK_CYCLES=20).
module tb_vehicle_sensor_conditioner;
  import traffic_pkg::*;

  localparam int unsigned DEB = 4;
  localparam int unsigned STK = 20;
`ifdef SENSOR_STUCK_DET_EN
  localparam logic STUCK_EN = 1'b1;
`else
  localparam logic STUCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sensor_raw = 1'b0;
  logic       req_ack = 1'b0;
  logic       veh_req;
  logic [7:0] veh_count;
  logic       stuck_fault;

  int n_checks = 0;
  int n_fail   = 0;

  vehicle_sensor_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (8),
    .STUCK_CYCLES    (STK),
    .STUCK_W         (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sensor_raw  (sensor_raw),
    .req_ack     (req_ack),
    .veh_req     (veh_req),
    .veh_count   (veh_count),
    .stuck_fault (stuck_fault)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_req",   32'(veh_req),     32'd0);
    check("rst_count", 32'(veh_count),   32'd0);
    check("rst_fault", 32'(stuck_fault), 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));
    rst = 1'b1;
    tick(1);

    // Arrival: veh_req rises on the 6th edge after the raw rise
    sensor_raw = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      check("arr_early_req", 32'(veh_req), 32'd0);
    end
    tick(1);
    check("arr_req",   32'(veh_req),   32'd1);
    check("arr_count", 32'(veh_count), 32'd1);
    tick(6);
    sensor_raw = 1'b0;
    tick(10);
    check("arr_held_req",  32'(veh_req),     32'd1);
    check("arr_idle",      32'(dut.r_state), 32'(IDLE));
    req_ack = 1'b1;
    tick(1);
    req_ack = 1'b0;
    check("ack_clear_req", 32'(veh_req), 32'd0);
    req_ack = 1'b1;
    tick(1);
    req_ack = 1'b0;
    check("ack_idle_req",   32'(veh_req),   32'd0);
    check("ack_idle_count", 32'(veh_count), 32'd1);

    // Glitch rejection: 3 high then 10 low
    do_reset();
    sensor_raw = 1'b1;
    tick(3);
    sensor_raw = 1'b0;
    tick(10);
    check("glitch_req",   32'(veh_req),     32'd0);
    check("glitch_count", 32'(veh_count),   32'd0);
    check("glitch_state", 32'(dut.r_state), 32'(IDLE));

    // Simultaneous ack and arrival
    do_reset();
    sensor_raw = 1'b1;
    tick(6);
    check("sim_first_req", 32'(veh_req), 32'd1);
    tick(2);
    sensor_raw = 1'b0;
    tick(10);
    sensor_raw = 1'b1;
    tick(5);
    req_ack = 1'b1;
    tick(1);
    req_ack = 1'b0;
    check("sim_req",   32'(veh_req),   32'd1);
    check("sim_count", 32'(veh_count), 32'd2);
    req_ack = 1'b1;
    tick(1);
    req_ack = 1'b0;
    check("sim_after_ack_req", 32'(veh_req), 32'd0);
    sensor_raw = 1'b0;
    tick(10);

    // Reset mid-qualification
    sensor_raw = 1'b1;
    tick(4);
    check("mq_state_qual", 32'(dut.r_state), 32'(QUAL_ON));
    rst = 1'b0;
    #1;
    check("mq_req",   32'(veh_req),     32'd0);
    check("mq_count", 32'(veh_count),   32'd0);
    check("mq_fault", 32'(stuck_fault), 32'd0);
    check("mq_state", 32'(dut.r_state), 32'(IDLE));
    tick(1);
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      check("mq_early_req", 32'(veh_req), 32'd0);
    end
    tick(1);
    check("mq_arr_req",   32'(veh_req),   32'd1);
    check("mq_arr_count", 32'(veh_count), 32'd1);
    sensor_raw = 1'b0;
    tick(10);

    // Saturation over 260 arrivals
    do_reset();
    for (int n = 1; n <= 260; n++) begin
      sensor_raw = 1'b1;
      tick(7);
      sensor_raw = 1'b0;
      tick(7);
      if (n == 1 || n == 254 || n == 255 || n == 256 || n == 260) begin
        check("sat_count", 32'(veh_count), (n > 255) ? 32'd255 : 32'(n));
      end
    end
    check("sat_req", 32'(veh_req), 32'd1);

    // Stuck loop: raw held high for 40 cycles
    do_reset();
    sensor_raw = 1'b1;
    tick(6);
    check("stk_arr_req", 32'(veh_req), 32'd1);
    tick(19);
    check("stk_fault_early", 32'(stuck_fault), 32'd0);
    tick(1);
    check("stk_fault_set", 32'(stuck_fault), 32'(STUCK_EN));
    tick(3);
    req_ack = 1'b1;
    tick(1);
    req_ack = 1'b0;
    check("stk_ack_req", 32'(veh_req), 32'(STUCK_EN));
    tick(10);
    sensor_raw = 1'b0;
    tick(12);
    check("stk_fault_sticky", 32'(stuck_fault), 32'(STUCK_EN));
    check("stk_req_final",    32'(veh_req),     32'(STUCK_EN));
    check("stk_state",        32'(dut.r_state), 32'(IDLE));
    check("stk_count",        32'(veh_count),   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vehicle_sensor_conditioner.md
# vehicle_sensor_conditioner

Per-approach front end that turns a raw, asynchronous vehicle-loop input into a clean, latched service request for the traffic light controller's `sensor` input. It synchronises and debounces the loop and holds the request until the controller acknowledges that it served the approach. It also keeps a saturating vehicle count and flags a loop stuck at "occupied". One instance sits in front of each controller in the multi-intersection array.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronised samples required to change the qualified level; legal range 1 to 2^CNT_W-1.
- `CNT_W`, 8: debounce counter width.
- `STUCK_CYCLES`, 60000: consecutive cycles in PRESENT before the stuck fault is raised; legal range 1 to 2^STUCK_W-1.
- `STUCK_W`, 16: stuck timer width.

Ports:
- `clk` in 1: single clock; all flops are on the rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `sensor_raw` in 1: raw loop detector, asynchronous to `clk`.
- `req_ack` in 1: one-cycle pulse from the controller when the approach's green is granted.
- `veh_req` out 1: latched service request that drives the controller's `sensor`.
- `veh_count` out 8: count of qualified arrivals, saturating at 255.
- `stuck_fault` out 1: sticky stuck-loop flag.

## Operation
- `sensor_raw` passes through a 2-flop synchroniser to give `sensor_s`.
- The FSM has four states:
  - IDLE: transitions when `sensor_s`=1.
  - QUAL_ON: counts consecutive `sensor_s`=1 samples.
  - PRESENT: transitions when `sensor_s`=0.
  - QUAL_OFF: counts consecutive `sensor_s`=0 samples.
- Transitions:
  - IDLE→QUAL_ON when `sensor_s`=1, counter loaded with 1.
  - QUAL_ON→PRESENT when the counter reaches DEBOUNCE_CYCLES with `sensor_s`=1.
  - QUAL_ON→IDLE on any `sensor_s`=0, counter cleared.
  - PRESENT→QUAL_OFF and QUAL_OFF→IDLE/PRESENT work symmetrically.
  - With DEBOUNCE_CYCLES=1, IDLE goes directly to PRESENT.
- Arrival event: the edge that enters PRESENT from QUAL_ON or IDLE.
  - It sets `veh_req`.
  - It increments `veh_count`, which holds at 255.
- Request latch: `req_ack` clears `veh_req` on the next edge. If an arrival event coincides with `req_ack`, the set wins and `veh_req` stays 1.
- `req_ack` while `veh_req`=0 has no effect.
- Stuck detection:
  - The timer counts cycles in PRESENT and clears on leaving PRESENT.
  - When it reaches STUCK_CYCLES, `stuck_fault` is set.
  - `stuck_fault` stays set until reset.
  - While `stuck_fault`=1, `veh_req` is forced to 1 (fail-safe: the approach is always served).
- Counter widths are fixed. No counter wraps: the debounce and stuck counters stop at their terminal values.

## Timing
- Reset values: `veh_req`=0, `veh_count`=0, `stuck_fault`=0, FSM=IDLE, synchroniser flops=0, all counters=0.
- Reset asserted mid-qualification or mid-request clears everything immediately. No arrival is recorded.
- Latency: a clean `sensor_raw` rise to `veh_req`=1 takes DEBOUNCE_CYCLES+2 clock cycles (2 for synchronisation, DEBOUNCE_CYCLES for qualification).
- Pulses shorter than DEBOUNCE_CYCLES synchronised samples produce no change.
- `req_ack` to `veh_req`=0 takes 1 cycle.
- All outputs are registered, with no combinational path from input to output.

## Configuration
- `SENSOR_STUCK_DET_EN` defined: stuck timer and `stuck_fault` logic are present as described.
- `SENSOR_STUCK_DET_EN` not defined:
  - The timer is not built.
  - `stuck_fault` is tied to 0.
  - `veh_req` is driven only by the request latch.
  - STUCK_CYCLES and STUCK_W are ignored.

## Structure
- Shared package `traffic_pkg` holds:
  - the FSM state typedef (`sens_state_t`: IDLE, QUAL_ON, PRESENT, QUAL_OFF);
  - the `VEH_COUNT_MAX`=255 constant.
- Sub-module `sync2`: 2-flop synchroniser with the same async active-low reset. It is reusable for other asynchronous inputs in the array.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and STUCK_CYCLES=20.
- Sensor arrival and acknowledge: `sensor_raw` goes high for 12 cycles.
  - `veh_req` rises exactly 6 cycles after the raw edge and `veh_count`=1.
  - A `req_ack` pulse then gives `veh_req`=0 on the next cycle.
- Glitch rejection: `sensor_raw` goes high for 3 cycles, then low for 10. `veh_req` stays 0 and `veh_count` stays 0.
- Simultaneous ack and arrival: a second arrival lands on the same edge as `req_ack`. `veh_req` stays 1 and `veh_count`=2.
- Stuck sensor: `sensor_raw` is held high for 40 cycles.
  - `stuck_fault`=1 20 cycles after entering PRESENT.
  - `req_ack` no longer drops `veh_req`.
  - After `sensor_raw`=0, `stuck_fault` remains 1.
  - When the macro is undefined, `stuck_fault` stays 0 throughout.
- Reset mid-qualification: `rst`=0 for 1 cycle during QUAL_ON. All outputs are 0 and the FSM is in IDLE. The next arrival needs the full 6 cycles.
- Saturation: 260 clean arrivals. `veh_count` reads 255 and does not wrap.
